data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the CPU load/store path (port 0) and the program/debug loader (port 1). It sits between both requesters and the data memory's address, write-data, write-enable and read-data pins, and grants exactly one requester per cycle. Port 0 has fixed priority, and a saturating wait counter protects port 1 from starvation. It also range-checks addresses against the memory depth, and returns registered read data with a valid/error pulse.

---
 rtl/data_mem_pkg.sv | 17 +
 rtl/arb_resp_reg.sv | 54 +++++
 rtl/data_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter.
//   DATA_W / ADDR_W : default data and address widths
//   DEFAULT_DEPTH   : default number of valid memory words
//   owner_e         : encoding of the last-owner tracking FSM
package data_mem_pkg;

  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 32;
  localparam int DEFAULT_DEPTH = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_resp_reg.sv
// Registered response stage for one arbiter port.
// Captures memory read data on an in-range granted read and produces
// one-cycle rvalid / err pulses the cycle after the grant.
// Ports:
//   clk, reset        : clock, async active-high reset
//   gnt, we, in_range : grant, write flag and range result of this cycle
//   mem_rdata         : combinational read data from the memory
//   rdata, rvalid, err: registered response to the requester
module arb_resp_reg
  import data_mem_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gnt,
  input  logic          we,
  input  logic          in_range,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          err
);

  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic          rd_hit;

  always_comb begin
    rd_hit   = gnt && !we && in_range;
    // rdata only moves on a successful read; errors leave it untouched.
    rdata_d  = rd_hit ? mem_rdata : rdata_q;
    rvalid_d = rd_hit;
    err_d    = gnt && !in_range;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-ported data memory.
// Port 0 (CPU) has fixed priority; port 1 (loader) is forced through after
// MAX_WAIT consecutive denied cycles. Addresses >= DEPTH are rejected:
// writes are dropped and the port gets an err pulse.
// Handshake: a requester raises mX_req with addr/we/wdata stable and holds
// them until mX_gnt is seen high; mX_gnt is high for exactly one cycle and
// the access completes in that cycle. Read data / err come back one cycle
// later as a single-cycle mX_rvalid / mX_err pulse.
// Ports:
//   clk, reset                   : clock, async active-high reset
//   mX_req/we/addr/wdata         : requests from port X
//   mX_gnt                       : combinational grant to port X
//   mX_rdata/rvalid/err          : registered response to port X
//   mem_addr/wdata/we, mem_rdata : data memory pins
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int DW       = DATA_W,
  parameter int AW       = ADDR_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic          m1_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            WCW       = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);
  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  owner_e         owner_q, owner_d;
  logic           force_m1;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           in_range;

  // Grant decision and memory pin mux.
  always_comb begin
    force_m1  = m1_req && (wait_cnt_q == WAIT_SAT);
    m1_gnt    = !reset && m1_req && (force_m1 || !m0_req);
    m0_gnt    = !reset && m0_req && !force_m1;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (m1_gnt) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else if (m0_gnt) begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
    in_range  = ({1'b0, sel_addr} < DEPTH_EXT);
    mem_addr  = sel_addr;
    mem_wdata = sel_wdata;
    mem_we    = sel_we && in_range;
  end

  // Starvation counter for port 1: counts consecutive denied cycles.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (m1_gnt || !m1_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_SAT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Last-owner FSM: records which port held the memory in the previous cycle.
  always_comb begin
    owner_d = IDLE;
    if (m0_gnt) begin
      owner_d = OWN0;
    end else if (m1_gnt) begin
      owner_d = OWN1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      owner_q    <= IDLE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      owner_q    <= owner_d;
    end
  end

  arb_resp_reg #(.DW(DW)) u_resp0 (
    .clk       (clk),
    .reset     (reset),
    .gnt       (m0_gnt),
    .we        (m0_we),
    .in_range  (in_range),
    .mem_rdata (mem_rdata),
    .rdata     (m0_rdata),
    .rvalid    (m0_rvalid),
    .err       (m0_err)
  );

  arb_resp_reg #(.DW(DW)) u_resp1 (
    .clk       (clk),
    .reset     (reset),
    .gnt       (m1_gnt),
    .we        (m1_we),
    .in_range  (in_range),
    .mem_rdata (mem_rdata),
    .rdata     (m1_rdata),
    .rvalid    (m1_rvalid),
    .err       (m1_err)
  );

  a_one_hot_gnt : assert property (@(posedge clk) disable iff (reset)
    !(m0_gnt && m1_gnt));
  a_owner0 : assert property (@(posedge clk) disable iff (reset)
    m0_gnt |=> (owner_q == OWN0));
  a_owner1 : assert property (@(posedge clk) disable iff (reset)
    m1_gnt |=> (owner_q == OWN1));

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int DEPTH    = 100;
  localparam int MAX_WAIT = 4;
  localparam int W        = 65;  // {due_cycle[31:0], err, data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- DUT ----------------
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  data_mem_arbiter #(.DW(32), .AW(32), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // ---------------- memory environment ----------------
  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  logic        mem_init = 1'b1;
  logic [31:0] tb_mem [0:DEPTH-1];
  logic [6:0]  mem_idx;
  assign mem_idx   = mem_addr[6:0];
  assign mem_rdata = (mem_addr < DEPTH) ? tb_mem[mem_idx] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
    end else if (mem_we && mem_addr < DEPTH) begin
      tb_mem[mem_idx] <= mem_wdata;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] last_rd [0:1];
  int          w_model = 0;      // consecutive denied cycles of port 1
  int          prev_owner = 0;   // 0 none, 1 port0, 2 port1
  logic        mon_en = 1'b0;

  // pending transactions (held until granted)
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic serve(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic [W-1:0] e;
    if (addr >= DEPTH) begin
      e = {cyc + 32'd1, 1'b1, last_rd[p]};
    end else if (we) begin
      ref_mem[addr[6:0]] = wdata;
      return;
    end else begin
      last_rd[p] = ref_mem[addr[6:0]];
      e = {cyc + 32'd1, 1'b0, last_rd[p]};
    end
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // One arbitration cycle: drive pending requests, check the grant and the
  // memory pins against the model, then record expected responses.
  task automatic step();
    logic eg0, eg1, force1, ewe;
    logic [31:0] eaddr, ewdata;
    @(negedge clk);
    #1;
    m0_req = p0_req; m0_we = p0_we; m0_addr = p0_addr; m0_wdata = p0_wdata;
    m1_req = p1_req; m1_we = p1_we; m1_addr = p1_addr; m1_wdata = p1_wdata;
    #1;
    force1 = p1_req && (w_model == MAX_WAIT);
    eg1    = p1_req && (force1 || !p0_req);
    eg0    = p0_req && !eg1;
    eaddr  = eg1 ? p1_addr  : (eg0 ? p0_addr  : 32'd0);
    ewdata = eg1 ? p1_wdata : (eg0 ? p0_wdata : 32'd0);
    ewe    = (eg1 && p1_we && p1_addr < DEPTH) || (eg0 && p0_we && p0_addr < DEPTH);
    chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
    chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_wdata", mem_wdata, ewdata);
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("wait_cnt", 32'(dut.wait_cnt_q), 32'(w_model));
    chk("last_owner", 32'(dut.owner_q), 32'(prev_owner));
    if (eg0) serve(0, p0_we, p0_addr, p0_wdata);
    if (eg1) serve(1, p1_we, p1_addr, p1_wdata);
    if (eg1 || !p1_req) w_model = 0;
    else if (w_model < MAX_WAIT) w_model++;
    prev_owner = eg0 ? 1 : (eg1 ? 2 : 0);
    if (eg0) p0_req = 0;
    if (eg1) p1_req = 0;
  endtask

  // Monitor: checks each port's response whenever the DUT presents one,
  // and flags responses that are missing at their due cycle.
  task automatic mon_port(input int p, input logic rv, input logic er, input logic [31:0] rd);
    logic [W-1:0] head;
    bit due;
    head = '0;
    if (p == 0) due = (exp_q0.size() > 0) && (exp_q0[0][64:33] == cyc);
    else        due = (exp_q1.size() > 0) && (exp_q1[0][64:33] == cyc);
    if (due) begin
      if (p == 0) head = exp_q0.pop_front();
      else        head = exp_q1.pop_front();
      chk($sformatf("p%0d_rvalid", p), 32'(rv), 32'(!head[32]));
      chk($sformatf("p%0d_err", p), 32'(er), 32'(head[32]));
      chk($sformatf("p%0d_rdata", p), rd, head[31:0]);
    end else if (rv || er) begin
      chk($sformatf("p%0d_unexpected_resp", p), {30'd0, er, rv}, 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon_port(0, m0_rvalid, m0_err, m0_rdata);
        mon_port(1, m1_rvalid, m1_err, m1_rdata);
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6)  return 32'($urandom_range(0, DEPTH - 1));
    if (r == 7)  return 32'(DEPTH - 1);
    if (r == 8)  return 32'(DEPTH + $urandom_range(0, 3));
    return $urandom | 32'h8000_0000;
  endfunction

  // ---------------- stimulus ----------------
  int exp_wait [0:5];

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    exp_wait = '{0, 1, 2, 3, 4, 0};

    // Reset with requests raised: nothing may be granted.
    m0_req = 1; m0_we = 1; m0_addr = 32'd7; m0_wdata = 32'hAAAA_5555;
    m1_req = 1; m1_addr = 32'd8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("rst_err", {30'd0, m0_err, m1_err}, 32'd0);
    chk("rst_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    chk("rst_owner", 32'(dut.owner_q), 32'd0);
    m0_req = 0; m1_req = 0;
    mem_init = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;

    // Write 0xDEADBEEF to addr 5, then read it back on port 0.
    p0_req = 1; p0_we = 1; p0_addr = 32'd5; p0_wdata = 32'hDEAD_BEEF;
    step();
    p0_req = 1; p0_we = 0; p0_addr = 32'd5;
    step();
    step();
    chk("t1_readback", m0_rdata, 32'hDEAD_BEEF);

    // Both ports requesting for 6 cycles: port 1 forced through on cycle 5.
    p1_req = 1; p1_we = 0; p1_addr = 32'd10;
    for (int k = 0; k < 6; k++) begin
      if (!p0_req) begin
        p0_req = 1; p0_we = 0; p0_addr = 32'($urandom_range(0, DEPTH - 1));
      end
      if (k == 5) p1_req = 0;
      chk("t2_wait_cnt_seq", 32'(w_model), 32'(exp_wait[k]));
      step();
      chk("t2_m1_gnt_seq", 32'(m1_gnt), 32'(k == 4));
    end
    p0_req = 0;
    step();

    // Port 1 write just past the end is dropped and flags an error.
    p1_req = 1; p1_we = 1; p1_addr = 32'(DEPTH); p1_wdata = 32'h5A5A_5A5A;
    step();
    chk("t3_mem_we", 32'(mem_we), 32'd0);
    p1_req = 1; p1_we = 0; p1_addr = 32'd0;
    step();
    // Port 1 alone reading the last legal word.
    p1_req = 1; p1_we = 0; p1_addr = 32'(DEPTH - 1);
    step();
    step();
    step();

    // Reset asserted while a port-0 write to addr 3 is being granted.
    @(negedge clk);
    #1;
    m0_req = 1; m0_we = 1; m0_addr = 32'd3; m0_wdata = 32'h0000_1234;
    #1;
    chk("t5_gnt_before_rst", 32'(m0_gnt), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_gnt_in_rst", 32'(m0_gnt), 32'd0);
    chk("t5_mem_we_in_rst", 32'(mem_we), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    m0_req = 0; m1_req = 0;
    #1;
    chk("t5_rvalid_after", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("t5_err_after", {30'd0, m0_err, m1_err}, 32'd0);
    chk("t5_wait_after", 32'(dut.wait_cnt_q), 32'd0);
    chk("t5_rdata_after", m0_rdata, 32'd0);
    w_model = 0; prev_owner = 0; last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    p0_req = 0; p1_req = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'd3;
    step();

    // Three idle cycles.
    repeat (3) step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if (!p0_req && $urandom_range(0, 99) < 60) begin
        p0_req = 1; p0_we = 1'($urandom_range(0, 1));
        p0_addr = rand_addr(); p0_wdata = $urandom;
      end
      if (!p1_req && $urandom_range(0, 99) < 45) begin
        p1_req = 1; p1_we = 1'($urandom_range(0, 1));
        p1_addr = rand_addr(); p1_wdata = $urandom;
      end
      step();
    end
    p0_req = 0; p1_req = 0;
    repeat (3) step();

    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
